// File: rtl/lb_arbiter.sv
// Round-robin local-bus arbiter: serialises up to four requesters onto one strobe/read bus.
// Optional per-port grant counters are built when LB_ARB_COUNT_EN is defined.
module lb_arbiter #(
    parameter int unsigned NREQ     = 2,
    parameter int unsigned READ_LAT = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ-1:0]      rd_i,
    input  logic [NREQ-1:0]      lock_i,
    input  logic [24*NREQ-1:0]   addr_i,
    input  logic [32*NREQ-1:0]   wdata_i,
    output logic [NREQ-1:0]      ack_o,
    output logic [31:0]          rdata_o,
    output logic [1:0]           gnt_id_o,
    output logic                 busy_o,
    output logic [23:0]          lb_addr_o,
    output logic                 lb_strobe_o,
    output logic                 lb_rd_o,
    output logic [31:0]          lb_wdata_o,
    input  logic [31:0]          lb_rdata_i,
    output logic [16*NREQ-1:0]   stat_cnt_o
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [1:0]      gnt_q, gnt_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [23:0]     addr_q, addr_d;
    logic            rd_q, rd_d;
    logic            strobe_q, busy_q;
    logic            arm_q;

    logic [3:0]      req4;
    logic [1:0]      idx, sel;
    logic            found;
    logic [23:0]     pick_addr;
    logic [31:0]     pick_wdata;
    logic            pick_rd, pick_lock;
    logic [NREQ-1:0] gnt_oh;

    assign req4 = 4'(req_i);

    // First requester at or after ptr, searching upward modulo NREQ.
    always_comb begin
        sel   = ptr_q;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = 2'((32'(ptr_q) + i) % NREQ);
            if (req4[idx] && !found) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        pick_addr  = '0;
        pick_wdata = '0;
        pick_rd    = 1'b0;
        pick_lock  = 1'b0;
        gnt_oh     = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            if (sel == 2'(k)) begin
                pick_addr  = addr_i[24*k +: 24];
                pick_wdata = wdata_i[32*k +: 32];
                pick_rd    = rd_i[k];
                pick_lock  = lock_i[k];
            end
            gnt_oh[k] = (gnt_q == 2'(k));
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        rdata_d = rdata_q;
        ack_d   = '0;
        unique case (state_q)
            StIdle: begin
                if (arm_q && found) begin
                    gnt_d   = sel;
                    addr_d  = pick_addr;
                    wdata_d = pick_wdata;
                    rd_d    = pick_rd;
                    if (pick_lock) ptr_d = sel;
                    else           ptr_d = (sel == 2'(NREQ - 1)) ? 2'd0 : sel + 2'd1;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (rd_q) begin
                    cnt_d   = 3'(READ_LAT - 1);
                    state_d = StWait;
                end else begin
                    ack_d   = gnt_oh;
                    state_d = StIdle;
                end
            end
            StWait: begin
                if (cnt_q == 3'd0) begin
                    rdata_d = lb_rdata_i;
                    ack_d   = gnt_oh;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // arm_q holds off the first grant until one clock after reset release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            ptr_q    <= '0;
            gnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_q     <= 1'b0;
            rdata_q  <= '0;
            ack_q    <= '0;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
            arm_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rd_q     <= rd_d;
            rdata_q  <= rdata_d;
            ack_q    <= ack_d;
            strobe_q <= (state_d == StIssue);
            busy_q   <= (state_d != StIdle);
            arm_q    <= 1'b1;
        end
    end

    assign ack_o       = ack_q;
    assign rdata_o     = rdata_q;
    assign gnt_id_o    = gnt_q;
    assign busy_o      = busy_q;
    assign lb_addr_o   = addr_q;
    assign lb_strobe_o = strobe_q;
    assign lb_rd_o     = rd_q;
    assign lb_wdata_o  = wdata_q;

`ifdef LB_ARB_COUNT_EN
    logic [16*NREQ-1:0] stat_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_q <= '0;
        end else begin
            for (int k = 0; k < int'(NREQ); k++) begin
                if (state_q == StIdle && state_d == StIssue && sel == 2'(k) &&
                    stat_q[16*k +: 16] != 16'hFFFF) begin
                    stat_q[16*k +: 16] <= stat_q[16*k +: 16] + 16'd1;
                end
            end
        end
    end

    assign stat_cnt_o = stat_q;
`else
    assign stat_cnt_o = '0;
`endif

endmodule

// File: tb/tb_lb_arbiter.sv
// Directed self-checking bench for lb_arbiter with NREQ=4, READ_LAT=2 and a fixed-latency slave.
module tb_lb_arbiter;
    localparam int unsigned NREQ = 4;
    localparam int unsigned RL   = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    req, rd, lock, ack;
    logic [95:0]   addr;
    logic [127:0]  wdata;
    logic [31:0]   rdata, lb_wdata, lb_rdata, resp;
    logic [1:0]    gnt;
    logic          busy, strobe, lb_rd;
    logic [23:0]   lb_addr;
    logic [63:0]   stat, exp_stat;
    logic [RL-1:0] sr;

    int n_tests = 0;
    int n_fail  = 0;
    logic [1:0] seq [64];
    int ns, a0, a1, last_ack, n_ack;

    always #5 clk = ~clk;

    lb_arbiter #(.NREQ(NREQ), .READ_LAT(RL)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .rd_i(rd), .lock_i(lock),
        .addr_i(addr), .wdata_i(wdata), .ack_o(ack), .rdata_o(rdata), .gnt_id_o(gnt),
        .busy_o(busy), .lb_addr_o(lb_addr), .lb_strobe_o(strobe), .lb_rd_o(lb_rd),
        .lb_wdata_o(lb_wdata), .lb_rdata_i(lb_rdata), .stat_cnt_o(stat)
    );

    // Slave: read data valid only RL cycles after the strobe cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sr <= '0;
        else        sr <= {sr[RL-2:0], strobe & lb_rd};
    end
    assign lb_rdata = sr[RL-1] ? resp : 32'hBAD0_BAD0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_burst(input int lim0, input int lim1, input int unlock_at, input int ncyc);
        ns = 0; a0 = 0; a1 = 0; last_ack = 0;
        for (int c = 1; c <= ncyc; c++) begin
            tick();
            if (strobe && ns < 64) begin
                seq[ns] = gnt;
                ns++;
            end
            if (ack[0]) begin
                a0++;
                last_ack = c;
                if (a0 == unlock_at) lock[0] = 1'b0;
                if (a0 >= lim0) req[0] = 1'b0;
            end
            if (ack[1]) begin
                a1++;
                last_ack = c;
                if (a1 >= lim1) req[1] = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0; rd = '0; lock = '0;
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();
    endtask

    initial begin
        logic [1:0] lock_seq [7];
        lock_seq = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd1};
`ifdef LB_ARB_COUNT_EN
        exp_stat = 64'h0000_0000_0008_0008;
`else
        exp_stat = 64'h0;
`endif
        rst_n = 1'b0;
        req = '0; rd = '0; lock = '0; addr = '0; wdata = '0; resp = '0;
        tick(); tick();
        chk("rst_ack", 64'(ack), 64'h0);
        chk("rst_rdata", 64'(rdata), 64'h0);
        chk("rst_gnt", 64'(gnt), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_strobe", 64'(strobe), 64'h0);
        chk("rst_lb_addr", 64'(lb_addr), 64'h0);
        chk("rst_lb_wdata", 64'(lb_wdata), 64'h0);
        chk("rst_lb_rd", 64'(lb_rd), 64'h0);
        chk("rst_stat", stat, 64'h0);
        rst_n = 1'b1;
        tick(); tick();

        // Single write from port 0; address changes after grant must be ignored.
        addr[23:0] = 24'h050002; wdata[31:0] = 32'h0000_007F; req[0] = 1'b1;
        tick();
        chk("wr_strobe", 64'(strobe), 64'h1);
        chk("wr_addr", 64'(lb_addr), 64'h050002);
        chk("wr_wdata", 64'(lb_wdata), 64'h7F);
        chk("wr_rd", 64'(lb_rd), 64'h0);
        chk("wr_busy", 64'(busy), 64'h1);
        chk("wr_ack_c1", 64'(ack), 64'h0);
        req[0] = 1'b0; addr[23:0] = 24'hFFFFFF;
        tick();
        chk("wr_ack_c2", 64'(ack), 64'h1);
        chk("wr_strobe_c2", 64'(strobe), 64'h0);
        chk("wr_busy_c2", 64'(busy), 64'h0);
        chk("wr_addr_hold", 64'(lb_addr), 64'h050002);
        tick();
        chk("wr_ack_c3", 64'(ack), 64'h0);

        // Single read from port 1.
        addr[47:24] = 24'h0; rd[1] = 1'b1; resp = 32'h4865_6C6C; req[1] = 1'b1;
        tick();
        chk("rd_strobe", 64'(strobe), 64'h1);
        chk("rd_lb_rd", 64'(lb_rd), 64'h1);
        chk("rd_gnt", 64'(gnt), 64'h1);
        chk("rd_busy_c1", 64'(busy), 64'h1);
        req[1] = 1'b0;
        tick();
        chk("rd_busy_c2", 64'(busy), 64'h1);
        chk("rd_strobe_c2", 64'(strobe), 64'h0);
        chk("rd_ack_c2", 64'(ack), 64'h0);
        tick();
        chk("rd_busy_c3", 64'(busy), 64'h1);
        chk("rd_ack_c3", 64'(ack), 64'h0);
        tick();
        chk("rd_ack_c4", 64'(ack), 64'h2);
        chk("rd_rdata", 64'(rdata), 64'h4865_6C6C);
        chk("rd_busy_c4", 64'(busy), 64'h0);

        // Contention: ports 0 and 1, eight writes each, from a fresh reset.
        do_reset();
        req[0] = 1'b1; req[1] = 1'b1;
        run_burst(8, 8, 99, 40);
        chk("cont_grants", 64'(ns), 64'd16);
        for (int i = 0; i < 16; i++) chk($sformatf("cont_seq%0d", i), 64'(seq[i]), 64'(i % 2));
        chk("cont_acks0", 64'(a0), 64'd8);
        chk("cont_acks1", 64'(a1), 64'd8);
        chk("cont_last_ack", 64'(last_ack), 64'd32);
        chk("cont_stat", stat, exp_stat);

        // Lock: port 0 keeps priority until it drops lock after its third ack.
        lock[0] = 1'b1; req[0] = 1'b1; req[1] = 1'b1;
        run_burst(5, 2, 3, 30);
        chk("lock_grants", 64'(ns), 64'd7);
        for (int i = 0; i < 7; i++) chk($sformatf("lock_seq%0d", i), 64'(seq[i]), 64'(lock_seq[i]));

        // Reset in the WAIT state of a read.
        rd[1] = 1'b1; resp = 32'hCAFE_0001; req[1] = 1'b1;
        tick();
        chk("rr_strobe", 64'(strobe), 64'h1);
        req[1] = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("rr_strobe0", 64'(strobe), 64'h0);
        chk("rr_busy0", 64'(busy), 64'h0);
        chk("rr_ack0", 64'(ack), 64'h0);
        chk("rr_rdata0", 64'(rdata), 64'h0);
        tick();
        rst_n = 1'b1; resp = 32'h1234_5678; req[1] = 1'b1; n_ack = 0;
        tick();
        chk("rr_arm_strobe", 64'(strobe), 64'h0);
        if (ack != 4'h0) n_ack++;
        tick();
        chk("rr_new_strobe", 64'(strobe), 64'h1);
        chk("rr_new_gnt", 64'(gnt), 64'h1);
        req[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (ack != 4'h0) n_ack++;
        end
        chk("rr_no_stale_ack", 64'(n_ack), 64'h0);
        tick();
        chk("rr_new_ack", 64'(ack), 64'h2);
        chk("rr_new_rdata", 64'(rdata), 64'h1234_5678);

        // Pointer wrap with NREQ=4: after a grant to port 3, port 0 wins over port 3.
        rd = '0; req[3] = 1'b1;
        tick();
        chk("wrap_gnt3", 64'(gnt), 64'h3);
        req[0] = 1'b1;
        tick();
        chk("wrap_ack3", 64'(ack), 64'h8);
        tick();
        chk("wrap_gnt0", 64'(gnt), 64'h0);
        chk("wrap_strobe", 64'(strobe), 64'h1);
        req[0] = 1'b0;
        tick();
        chk("wrap_ack0", 64'(ack), 64'h1);
        tick();
        chk("wrap_gnt3_again", 64'(gnt), 64'h3);
        req[3] = 1'b0;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
